layer_featuremap_streamer: RTL
==============================

# layer_featuremap_streamer

Frame-buffer reader that feeds a layer's feature-map convolution bank. On `start` it reads one IMG_SIZE×IMG_SIZE feature map, all CHANNELS channels per word, from a synchronous-read buffer in raster order. It presents each pixel as a packed CHANNELS×DATA_WIDTH word with a one-cycle `valid_out` strobe, which drives the bank's `data_in`/`valid_in` pair. It is the producer side of that stream. Its position tags (`row_last`, `frame_last`) and the `done` strobe sequence the next layer.

## Interface
- DATA_WIDTH, 32, bits per channel sample (IEEE-754 single)
- CHANNELS, 32, channels packed per word; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- IMG_SIZE, 104, feature-map width = height
- ADDR_WIDTH, 14, buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMG_SIZE²
- RD_LATENCY, 1, buffer read latency in cycles (≥1)

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  reset, synchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- stall  in  1  suppress new reads while high
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_WIDTH  buffer read address
- rd_data  in  CHANNELS*DATA_WIDTH  buffer read data, valid RD_LATENCY cycles after rd_en
- data_out  out  CHANNELS*DATA_WIDTH  packed pixel word
- valid_out  out  1  data_out valid this cycle
- row_last  out  1  with valid_out: last column of a row
- frame_last  out  1  with valid_out: last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final valid_out

## Operation
- States are IDLE, STREAM and DRAIN.
- IDLE: when `start` is high, clear the pixel/row/col counters, then go to STREAM and set busy=1.
- STREAM:
  - rd_en = !stall (combinational from registered state plus stall); rd_addr = pixel counter.
  - On each rd_en, the counter increments and col wraps at IMG_SIZE-1 (row increments).
  - When the read of pixel IMG_SIZE²-1 issues, go to DRAIN.
- DRAIN:
  - rd_en=0.
  - Wait until all in-flight reads have returned.
  - Assert done for one cycle, clear busy in the same cycle, and return to IDLE.
- A valid/row_last/frame_last tag shift register of depth RD_LATENCY tracks each read.
- The output register captures rd_data when the tag emerges. valid_out, row_last and frame_last are registered alongside it.
- data_out holds its last value when valid_out=0.
- `stall` only blocks new reads. Reads already in flight still emerge on valid_out; no data is dropped or duplicated.
- `start` while busy is ignored.
- Rst has priority over start.
- Rst mid-frame aborts the frame:
  - Next cycle: IDLE, rd_en=0, valid_out=0.
  - In-flight tags are cleared.
  - No done pulse is produced.
- rd_addr never exceeds IMG_SIZE²-1.

## Timing
- Reset values: rd_en=0, rd_addr=0, data_out=0, valid_out=0, row_last=0, frame_last=0, busy=0, done=0.
- Reference cycle 0 is the edge at which `start` is sampled. Unstalled schedule, with N=IMG_SIZE² and L=RD_LATENCY:
  - busy=1 from cycle 1.
  - rd_en in cycles 1..N, addr = cycle-1.
  - valid_out in cycles L+2..N+L+1.
  - done in cycle N+L+2.
- Each stalled cycle during STREAM delays every later event by exactly one cycle.
- Throughput is one pixel per cycle with no stall.
- `start` may be accepted in the cycle after done (back-to-back frames).

## Test plan
- Reset: hold Rst 3 cycles with start=1 → all outputs 0 and no rd_en; release → IDLE, busy=0.
- Full frame, IMG_SIZE=4, L=1:
  - Stimulus: start at cycle 0, buffer word = address replicated in every channel.
  - rd_addr 0..15 in cycles 1..16.
  - valid_out cycles 3..18 with data lane k = 0..15 in order.
  - row_last on pixels 3, 7, 11, 15; frame_last only on pixel 15.
  - done at cycle 19.
- Stall, IMG_SIZE=4:
  - Stimulus: stall high cycles 5–7.
  - No rd_en in cycles 5–7.
  - The two in-flight words still appear.
  - 16 unique, in-order words in total.
  - done at cycle 22.
- RD_LATENCY=3, IMG_SIZE=4 → first valid_out at cycle 5, done at cycle 21, data order intact.
- start pulsed at cycle 8 mid-frame → ignored; exactly 16 words and one done.
- Rst at cycle 6 mid-frame:
  - Cycle 7: valid_out=0, busy=0, no done.
  - A new start then yields a full frame from address 0.

Source files
------------

// File: rtl/layer_featuremap_streamer.sv
// Raster-order frame-buffer reader: issues one read per unstalled cycle and re-times the returned
// words into a valid/row_last/frame_last stream for the downstream convolution bank.
module layer_featuremap_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int IMG_SIZE   = 104,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           start,
    input  logic                           stall,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    output logic                           row_last,
    output logic                           frame_last,
    output logic                           busy,
    output logic                           done
);

    localparam int               POS_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic row_last;
        logic frame_last;
    } tag_t;

    state_t           state;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    tag_t             tags [RD_LATENCY];
    logic             in_flight;
    logic             last_col;
    logic             last_pix;

    // rd_addr doubles as the pixel counter; row/col only locate the row and frame boundaries.
    assign rd_en    = (state == STREAM) && !stall;
    assign last_col = (col == LAST_POS);
    assign last_pix = last_col && (row == LAST_POS);

    // NOTE: the accumulator gets a default before the loop so no latch is inferred.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight | tags[i].valid;
        end
    end

    // NOTE: every register here, the tag pipeline included, updates with <= so all stages
    // shift together; the tags are cleared on reset so an aborted frame leaves nothing in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            row        <= '0;
            col        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            row_last   <= 1'b0;
            frame_last <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr <= '0;
                        row     <= '0;
                        col     <= '0;
                        busy    <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        // The counter parks on the final address so rd_addr never leaves the frame.
                        if (last_pix) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            if (last_col) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!in_flight) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            tags[0].valid      <= rd_en;
            tags[0].row_last   <= rd_en && last_col;
            tags[0].frame_last <= rd_en && last_pix;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end

            // The tag leaves the pipeline in the same cycle its word is on rd_data.
            valid_out  <= tags[RD_LATENCY-1].valid;
            row_last   <= tags[RD_LATENCY-1].row_last;
            frame_last <= tags[RD_LATENCY-1].frame_last;
            if (tags[RD_LATENCY-1].valid) begin
                data_out <= rd_data;
            end
        end
    end

endmodule
